// File: rtl/param_data_mem_pkg.sv
// Shared definitions for the parametrised data memory:
// sweep FSM state type, default widths and a clog2 helper.
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Smallest r with 2**r >= n (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_data_mem_if.sv
// CPU-side bus of the data memory: access strobes, address/data,
// read results, sweep control/status and the debug window.
// master = CPU/bench side, slave = memory side.
interface param_data_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4
);
    logic                init_req;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data_in;
    logic                mem_write;
    logic                mem_read;
    logic [DATA_W-1:0]   data_out;
    logic                rd_valid;
    logic                addr_err;
    logic                busy;
    logic [IDX_W-1:0]    m_state;
    logic [2*DATA_W-1:0] m_data;

    modport master (
        output init_req, addr, data_in, mem_write, mem_read, m_state,
        input  data_out, rd_valid, addr_err, busy, m_data
    );

    modport slave (
        input  init_req, addr, data_in, mem_write, mem_read, m_state,
        output data_out, rd_valid, addr_err, busy, m_data
    );
endinterface

// File: rtl/param_data_mem_sweeper.sv
// Clear-sweep FSM: zeroes one word per cycle from index 0 to DEPTH-1.
// Ports: clk, clear (async high), init_req -> sweep_we, sweep_idx, busy.
module mem_clear_sweeper
    import mem_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int IDX_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             init_req,
    output logic             sweep_we,
    output logic [IDX_W-1:0] sweep_idx,
    output logic             busy
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= SWEEP;
            ptr   <= '0;
        end else if (init_req) begin
            // restart from word 0 whether idle or mid-sweep
            state <= SWEEP;
            ptr   <= '0;
        end else if (state == SWEEP) begin
            if (ptr == LAST) begin
                state <= IDLE;
                ptr   <= '0;
            end else begin
                ptr <= ptr + IDX_W'(1);
            end
        end
    end

    // the restart edge itself does not write
    assign sweep_we  = (state == SWEEP) && !init_req;
    assign sweep_idx = ptr;
    assign busy      = (state == SWEEP);

endmodule

// File: rtl/param_data_mem.sv
// Register-backed data memory: one registered read/write port, clear sweep,
// two-word debug window. Ports: clk, clear (async high), bus (slave).
module param_data_mem
    import mem_pkg::*;
#(
    parameter  int DATA_W      = DATA_W_DEF,
    parameter  int ADDR_W      = 16,
    parameter  int DEPTH       = DEPTH_DEF,
    parameter  int WRITE_FIRST = 0,
    localparam int IDX_W       = clog2(DEPTH)
) (
    input logic           clk,
    input logic           clear,
    param_data_mem_if.slave bus
);
    localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W:0]   DEPTH_I = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              sweep_we;
    logic [IDX_W-1:0]  sweep_idx;
    logic              busy;

    logic              open;
    logic              in_rng;
    logic              wr;
    logic              rd;
    logic              err;
    logic              dbg_ok;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  nxt;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                err_q;
    logic [2*DATA_W-1:0] dbg_q;

    mem_clear_sweeper #(
        .DEPTH (DEPTH)
    ) u_sweep (
        .clk       (clk),
        .clear     (clear),
        .init_req  (bus.init_req),
        .sweep_we  (sweep_we),
        .sweep_idx (sweep_idx),
        .busy      (busy)
    );

    // init_req wins over a same-cycle CPU access
    assign open   = !busy && !bus.init_req;
    assign in_rng = {1'b0, bus.addr} < DEPTH_A;
    assign idx    = bus.addr[IDX_W-1:0];
    assign wr     = open && bus.mem_write && in_rng;
    assign rd     = open && bus.mem_read;
    assign err    = open && (bus.mem_read || bus.mem_write) && !in_rng;

    // single address bus: a read and write in one cycle always collide
    assign rd_word = (WRITE_FIRST != 0 && wr) ? bus.data_in : mem[idx];

    assign dbg_ok = {1'b0, bus.m_state} < DEPTH_I;
    assign nxt    = (bus.m_state == LAST) ? '0 : bus.m_state + IDX_W'(1);

    // array has no reset; the sweep zeroes it
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_idx] <= '0;
        end else if (wr) begin
            mem[idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            dbg_q   <= '0;
        end else begin
            valid_q <= rd;
            err_q   <= err;
            if (rd) data_q <= in_rng ? rd_word : '0;
            dbg_q <= dbg_ok ? {mem[bus.m_state], mem[nxt]} : '0;
        end
    end

    assign bus.data_out = data_q;
    assign bus.rd_valid = valid_q;
    assign bus.addr_err = err_q;
    assign bus.busy     = busy;
    assign bus.m_data   = dbg_q;

endmodule

// File: tb/tb_param_data_mem.sv
// Self-checking bench for param_data_mem: DEPTH=16/WRITE_FIRST=0 (a)
// and DEPTH=12/WRITE_FIRST=1 (b), scoreboard of expected reads.
module tb_param_data_mem;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    param_data_mem_if #(.DATA_W(16), .ADDR_W(16), .IDX_W(4)) a();
    param_data_mem_if #(.DATA_W(16), .ADDR_W(16), .IDX_W(4)) b();

    param_data_mem #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(16), .WRITE_FIRST(0)
    ) dut_a (
        .clk(clk), .clear(clear), .bus(a.slave)
    );

    param_data_mem #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(12), .WRITE_FIRST(1)
    ) dut_b (
        .clk(clk), .clear(clear), .bus(b.slave)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q[$];
    exp_t        x;
    logic [15:0] ref_a [16];

    function automatic exp_t mk(input logic [15:0] d, input logic e);
        exp_t r;
        r.d = d;
        r.e = e;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a.init_req = 0; a.addr = 0; a.data_in = 0;
        a.mem_write = 0; a.mem_read = 0;
        b.init_req = 0; b.addr = 0; b.data_in = 0;
        b.mem_write = 0; b.mem_read = 0;
    endtask

    task automatic wr_a(input logic [15:0] ad, input logic [15:0] d);
        a.addr = ad; a.data_in = d; a.mem_write = 1;
        cyc();
        a.mem_write = 0;
        if (ad < 16) ref_a[ad[3:0]] = d;
    endtask

    task automatic test_reset();
        int cnt;
        int bcnt;
        idle_all();
        a.m_state = 0; b.m_state = 0;
        clear = 1;
        repeat (3) cyc();
        n_cmp++;
        if (a.data_out !== 0 || a.rd_valid !== 0 || a.addr_err !== 0
            || a.m_data !== 0) begin
            n_bad++;
            $display("FAIL reset_outs: got d=%h v=%b e=%b m=%h want all 0",
                     a.data_out, a.rd_valid, a.addr_err, a.m_data);
        end
        n_cmp++;
        if (a.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 1", a.busy);
        end
        clear = 0;
        cnt = 0; bcnt = 0;
        while (a.busy === 1'b1 && cnt < 60) begin
            cnt++;
            if (b.busy === 1'b1) bcnt++;
            cyc();
        end
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL sweep_len_16: got %0d want 16", cnt);
        end
        n_cmp++;
        if (bcnt != 12 || b.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sweep_len_12: got %0d busy=%b want 12 busy=0",
                     bcnt, b.busy);
        end
        for (int i = 0; i < 16; i++) ref_a[i] = 16'h0;
        for (int i = 0; i < 16; i++) begin
            a.addr = 16'(i); a.mem_read = 1;
            q.push_back(mk(ref_a[i], 1'b0));
            cyc();
            x = q.pop_front();
            n_cmp++;
            if (a.rd_valid !== 1'b1 || a.data_out !== x.d
                || a.addr_err !== x.e) begin
                n_bad++;
                $display("FAIL reset_read[%0d]: got d=%h v=%b e=%b want d=%h v=1 e=%b",
                         i, a.data_out, a.rd_valid, a.addr_err, x.d, x.e);
            end
        end
        a.mem_read = 0;
    endtask

    task automatic test_read_write();
        wr_a(16'd5, 16'hBEEF);
        a.addr = 5; a.mem_read = 1;
        q.push_back(mk(ref_a[5], 1'b0));
        cyc();
        a.mem_read = 0;
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d) begin
            n_bad++;
            $display("FAIL read_after_write: got d=%h v=%b want d=%h v=1",
                     a.data_out, a.rd_valid, x.d);
        end
        cyc();
        n_cmp++;
        if (a.rd_valid !== 1'b0 || a.data_out !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL read_hold: got d=%h v=%b want d=beef v=0",
                     a.data_out, a.rd_valid);
        end
        a.addr = 5; a.data_in = 16'h1234; a.mem_write = 1; a.mem_read = 1;
        q.push_back(mk(ref_a[5], 1'b0));
        ref_a[5] = 16'h1234;
        cyc();
        a.mem_write = 0; a.mem_read = 0;
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d) begin
            n_bad++;
            $display("FAIL rdw_read_first: got d=%h v=%b want d=%h v=1",
                     a.data_out, a.rd_valid, x.d);
        end
        a.addr = 5; a.mem_read = 1;
        q.push_back(mk(ref_a[5], 1'b0));
        cyc();
        a.mem_read = 0;
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d) begin
            n_bad++;
            $display("FAIL rdw_stored: got d=%h v=%b want d=%h v=1",
                     a.data_out, a.rd_valid, x.d);
        end
        b.addr = 5; b.data_in = 16'h1234; b.mem_write = 1; b.mem_read = 1;
        cyc();
        b.data_in = 16'h5678;
        cyc();
        b.mem_write = 0; b.mem_read = 0;
        n_cmp++;
        if (b.rd_valid !== 1'b1 || b.data_out !== 16'h5678) begin
            n_bad++;
            $display("FAIL rdw_write_first: got d=%h v=%b want d=5678 v=1",
                     b.data_out, b.rd_valid);
        end
    endtask

    task automatic test_out_of_range();
        wr_a(16'd0, 16'h5555);
        a.addr = 16'h0010; a.data_in = 16'hAAAA; a.mem_write = 1;
        cyc();
        a.mem_write = 0;
        n_cmp++;
        if (a.addr_err !== 1'b1 || a.rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_write_err: got e=%b v=%b want e=1 v=0",
                     a.addr_err, a.rd_valid);
        end
        cyc();
        n_cmp++;
        if (a.addr_err !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_err_pulse: got %b want 0", a.addr_err);
        end
        a.addr = 0; a.mem_read = 1;
        q.push_back(mk(ref_a[0], 1'b0));
        cyc();
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d
            || a.addr_err !== x.e) begin
            n_bad++;
            $display("FAIL oob_no_alias: got d=%h e=%b want d=%h e=%b",
                     a.data_out, a.addr_err, x.d, x.e);
        end
        a.addr = 16'h8003;
        q.push_back(mk(16'h0, 1'b1));
        cyc();
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d
            || a.addr_err !== x.e) begin
            n_bad++;
            $display("FAIL oob_read: got d=%h v=%b e=%b want d=%h v=1 e=%b",
                     a.data_out, a.rd_valid, a.addr_err, x.d, x.e);
        end
        a.mem_write = 1; a.data_in = 16'h7777;
        q.push_back(mk(16'h0, 1'b1));
        cyc();
        a.mem_write = 0; a.mem_read = 0;
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d
            || a.addr_err !== x.e) begin
            n_bad++;
            $display("FAIL oob_rw: got d=%h v=%b e=%b want d=%h v=1 e=%b",
                     a.data_out, a.rd_valid, a.addr_err, x.d, x.e);
        end
        cyc();
        n_cmp++;
        if (a.addr_err !== 1'b0 || a.rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_rw_pulse: got e=%b v=%b want 0 0",
                     a.addr_err, a.rd_valid);
        end
    endtask

    task automatic test_debug();
        logic [31:0] exp;
        wr_a(16'd15, 16'h000F);
        wr_a(16'd0, 16'h0A0A);
        a.m_state = 15;
        cyc();
        exp = {ref_a[15], ref_a[0]};
        n_cmp++;
        if (a.m_data !== exp) begin
            n_bad++;
            $display("FAIL dbg_wrap: got %h want %h", a.m_data, exp);
        end
        wr_a(16'd3, 16'h0003);
        wr_a(16'd4, 16'h0004);
        a.m_state = 3;
        cyc();
        exp = {ref_a[3], ref_a[4]};
        n_cmp++;
        if (a.m_data !== exp) begin
            n_bad++;
            $display("FAIL dbg_pair: got %h want %h", a.m_data, exp);
        end
        a.addr = 3; a.data_in = 16'h7777; a.mem_write = 1;
        cyc();
        a.mem_write = 0;
        n_cmp++;
        if (a.m_data !== exp) begin
            n_bad++;
            $display("FAIL dbg_pre_edge: got %h want %h", a.m_data, exp);
        end
        ref_a[3] = 16'h7777;
        cyc();
        exp = {ref_a[3], ref_a[4]};
        n_cmp++;
        if (a.m_data !== exp) begin
            n_bad++;
            $display("FAIL dbg_next: got %h want %h", a.m_data, exp);
        end
        b.addr = 11; b.data_in = 16'h00BB; b.mem_write = 1;
        cyc();
        b.addr = 0; b.data_in = 16'h00AA;
        cyc();
        b.mem_write = 0;
        b.m_state = 11;
        cyc();
        n_cmp++;
        if (b.m_data !== 32'h00BB00AA) begin
            n_bad++;
            $display("FAIL dbg_wrap_12: got %h want 00bb00aa", b.m_data);
        end
        b.m_state = 13;
        cyc();
        n_cmp++;
        if (b.m_data !== 32'h0) begin
            n_bad++;
            $display("FAIL dbg_oob_12: got %h want 0", b.m_data);
        end
    endtask

    task automatic test_init_sweep();
        int cnt;
        int seen;
        wr_a(16'd2, 16'h2222);
        a.init_req = 1;
        a.addr = 2; a.data_in = 16'hDEAD; a.mem_write = 1; a.mem_read = 1;
        cyc();
        a.init_req = 0;
        seen = 0;
        if (a.rd_valid !== 1'b0 || a.addr_err !== 1'b0) seen++;
        cnt = 0;
        while (a.busy === 1'b1 && cnt < 60) begin
            cnt++;
            cyc();
            if (a.rd_valid !== 1'b0 || a.addr_err !== 1'b0) seen++;
        end
        a.mem_write = 0; a.mem_read = 0;
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL init_len: got %0d want 16", cnt);
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL busy_access: got %0d responses want 0", seen);
        end
        for (int i = 0; i < 16; i++) ref_a[i] = 16'h0;
        for (int i = 0; i < 16; i++) begin
            a.addr = 16'(i); a.mem_read = 1;
            q.push_back(mk(ref_a[i], 1'b0));
            cyc();
            x = q.pop_front();
            n_cmp++;
            if (a.rd_valid !== 1'b1 || a.data_out !== x.d) begin
                n_bad++;
                $display("FAIL init_read[%0d]: got d=%h v=%b want d=%h v=1",
                         i, a.data_out, a.rd_valid, x.d);
            end
        end
        a.mem_read = 0;
        a.init_req = 1;
        cyc();
        a.init_req = 0;
        cnt = 0;
        while (a.busy === 1'b1 && cnt < 60) begin
            cnt++;
            a.init_req = (cnt == 7);
            cyc();
        end
        a.init_req = 0;
        n_cmp++;
        if (cnt != 23) begin
            n_bad++;
            $display("FAIL restart_len: got %0d want 23", cnt);
        end
    endtask

    task automatic test_clear();
        int cnt;
        wr_a(16'd6, 16'h6666);
        wr_a(16'd7, 16'h0707);
        a.m_state = 6;
        a.addr = 6; a.mem_read = 1;
        q.push_back(mk(ref_a[6], 1'b0));
        cyc();
        a.mem_read = 0;
        x = q.pop_front();
        n_cmp++;
        if (a.rd_valid !== 1'b1 || a.data_out !== x.d) begin
            n_bad++;
            $display("FAIL pre_clear_read: got d=%h v=%b want d=%h v=1",
                     a.data_out, a.rd_valid, x.d);
        end
        clear = 1;
        #1;
        n_cmp++;
        if (a.data_out !== 0 || a.rd_valid !== 0 || a.m_data !== 0
            || a.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL async_clear: got d=%h v=%b m=%h b=%b want 0 0 0 1",
                     a.data_out, a.rd_valid, a.m_data, a.busy);
        end
        cyc();
        clear = 0;
        cnt = 0;
        while (a.busy === 1'b1 && cnt < 60) begin
            cnt++;
            cyc();
        end
        a.addr = 16'h8003; a.mem_read = 1;
        cyc();
        a.mem_read = 0;
        clear = 1;
        #1;
        n_cmp++;
        if (a.addr_err !== 1'b0 || a.rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear_err: got e=%b v=%b want 0 0",
                     a.addr_err, a.rd_valid);
        end
        cyc();
        clear = 0;
        repeat (5) cyc();
        clear = 1;
        cyc();
        clear = 0;
        cnt = 0;
        while (a.busy === 1'b1 && cnt < 60) begin
            cnt++;
            cyc();
        end
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL mid_sweep_clear_len: got %0d want 16", cnt);
        end
        for (int i = 0; i < 16; i++) ref_a[i] = 16'h0;
        for (int i = 0; i < 16; i++) begin
            a.addr = 16'(i); a.mem_read = 1;
            q.push_back(mk(ref_a[i], 1'b0));
            cyc();
            x = q.pop_front();
            n_cmp++;
            if (a.rd_valid !== 1'b1 || a.data_out !== x.d) begin
                n_bad++;
                $display("FAIL clear_read[%0d]: got d=%h v=%b want d=%h v=1",
                         i, a.data_out, a.rd_valid, x.d);
            end
        end
        a.mem_read = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_write();
        test_out_of_range();
        test_debug();
        test_init_sweep();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
